// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 mux select through all channels and captures Y into a 16-bit word
module mux_scan_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        Y,
  output logic        S0,
  output logic        S1,
  output logic        S2,
  output logic        S3,
  output logic        busy,
  output logic        done,
  output logic [15:0] DATA
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [3:0] SET = 4'(SETTLE);
  state_t state, state_n;
  logic [3:0] idx, cnt;
  logic [15:0] shadow;
  logic last;
  assign last = (cnt == 4'd0) && (idx == 4'd15);
  assign {S3, S2, S1, S0} = idx;
  assign busy = (state == SCAN);
  assign done = (state == DONE);
  // next-state: start only honoured outside SCAN, final sample ends the scan
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SCAN : IDLE;
      SCAN:    state_n = last ? DONE : SCAN;
      DONE:    state_n = start ? SCAN : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state, channel stepping, settle counting and capture; DATA updates only on the final sample
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 4'd0;
      cnt    <= 4'd0;
      shadow <= 16'h0000;
      DATA   <= 16'h0000;
    end else begin
      state <= state_n;
      if (state != SCAN) begin
        idx    <= 4'd0;
        cnt    <= start ? SET : 4'd0;
        shadow <= 16'h0000;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        shadow[idx] <= Y;
        cnt         <= SET;
        idx         <= last ? 4'd0 : idx + 4'd1;
        if (last) DATA <= {Y, shadow[14:0]};
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of scan timing, capture, back-to-back, restart immunity and reset abort
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst, start1, start0;
  logic [15:0] in1, in0;
  logic y1, y0;
  logic a0, a1, a2, a3, busy1, done1;
  logic b0, b1, b2, b3, busy0, done0;
  logic [15:0] data1, data0;
  logic [3:0] s1, s0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  assign s1 = {a3, a2, a1, a0};
  assign s0 = {b3, b2, b1, b0};
  assign y1 = in1[s1];
  assign y0 = in0[s0];
  mux_scan_ctrl #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .start(start1), .Y(y1),
    .S0(a0), .S1(a1), .S2(a2), .S3(a3), .busy(busy1), .done(done1), .DATA(data1));
  mux_scan_ctrl #(.SETTLE(0)) u0 (.clk(clk), .rst(rst), .start(start0), .Y(y0),
    .S0(b0), .S1(b1), .S2(b2), .S3(b3), .busy(busy0), .done(done0), .DATA(data0));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; in1 = 16'h0; in0 = 16'h0;
    tick; tick;
    chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
    chk("rst_sel", s1, 0); chk("rst_data", data1, 16'h0000);
    start1 = 1'b1;
    tick;
    chk("rst_prio_busy", busy1, 0);
    rst = 1'b0; start1 = 1'b0;
    tick;
    chk("post_rst_idle_busy", busy1, 0); chk("post_rst_idle_done", done1, 0);
    in1 = 16'h8000;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      chk("t1_busy", busy1, 1); chk("t1_done", done1, 0);
      chk("t1_sel", s1, (c - 1) / 2); chk("t1_data_stable", data1, 16'h0000);
      tick;
    end
    chk("t1_done33", done1, 1); chk("t1_busy33", busy1, 0);
    chk("t1_sel33", s1, 0); chk("t1_data", data1, 16'h8000);
    tick;
    chk("t1_done34", done1, 0); chk("t1_busy34", busy1, 0); chk("t1_hold", data1, 16'h8000);
    in1 = 16'h1234;
    start1 = 1'b1;
    tick;
    for (int c = 1; c <= 32; c++) begin
      start1 = (c == 5);
      chk("t2_busy", busy1, 1); chk("t2_done", done1, 0);
      chk("t2_sel", s1, (c - 1) / 2); chk("t2_data_stable", data1, 16'h8000);
      tick;
    end
    start1 = 1'b0;
    chk("t2_done33", done1, 1); chk("t2_data", data1, 16'h1234);
    tick;
    chk("t2_idle", busy1, 0);
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c < 10; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t3_busy", busy1, 0); chk("t3_sel", s1, 0);
    chk("t3_data", data1, 16'h0000); chk("t3_done", done1, 0);
    for (int c = 0; c < 40; c++) begin
      chk("t3_no_done", done1, 0); chk("t3_no_busy", busy1, 0);
      tick;
    end
    in1 = 16'hA5C3;
    start1 = 1'b1;
    tick;
    start1 = 1'b0;
    for (int c = 1; c <= 32; c++) tick;
    chk("t3_done33", done1, 1); chk("t3_data2", data1, 16'hA5C3);
    tick;
    in1 = 16'h0F0F;
    start1 = 1'b1;
    tick;
    for (int c = 1; c <= 99; c++) begin
      chk("t4_done", done1, (c % 33) == 0);
      chk("t4_busy", busy1, (c % 33) != 0);
      if ((c % 33) == 0) chk("t4_data", data1, 16'h0F0F);
      if (c == 99) start1 = 1'b0;
      tick;
    end
    chk("t4_idle_busy", busy1, 0); chk("t4_idle_done", done1, 0);
    in0 = 16'h5555;
    start0 = 1'b1;
    tick;
    start0 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("t5_busy", busy0, 1); chk("t5_done", done0, 0); chk("t5_sel", s0, c - 1);
      tick;
    end
    chk("t5_done17", done0, 1); chk("t5_data", data0, 16'h5555); chk("t5_busy17", busy0, 0);
    tick;
    chk("t5_done18", done0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The module SHALL have parameter SETTLE, default 1, meaning the number of wait cycles after each select change before sampling (legal range 0..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: scan request, sampled only in IDLE or DONE.
REQ-005 The module SHALL have port Y, input, 1 bit: the output of the downstream mux16to1, sampled by this block.
REQ-006 The module SHALL have ports S0, S1, S2, S3, outputs, 1 bit each: mux select lines, S0 = LSB, S3 = MSB, driven from a registered 4-bit channel index.
REQ-007 The module SHALL have port busy, output, 1 bit: high while a scan is in progress.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle pulse marking a completed scan.
REQ-009 The module SHALL have port DATA, output, 16 bits: the captured word, where DATA[k] is the Y value sampled with select = k (DATA[0] = input A, DATA[15] = input P).

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-011 IDLE SHALL keep busy=0 and done=0, hold S3..S0 at 0, and hold DATA.
REQ-012 In IDLE or DONE, start=1 SHALL move the block to SCAN on the next edge, with channel index=0 and wait counter=SETTLE.
REQ-013 SCAN SHALL drive busy=1, done=0 and S3..S0 = channel index.
REQ-014 In SCAN with wait counter >0, the counter SHALL decrement by one per cycle while the channel index holds.
REQ-015 In SCAN with wait counter =0, Y SHALL be written into bit [index] of an internal shadow register at that edge.
REQ-016 On that same edge, if index <15 the index SHALL increment and the counter reload to SETTLE.
REQ-017 On that same edge, if index =15 the block SHALL enter DONE, copy the shadow register including the final bit into DATA, and return the index to 0.
REQ-018 Each channel SHALL therefore be presented for exactly SETTLE+1 cycles, and Y SHALL be sampled only in the last cycle of that window.
REQ-019 If start is sampled high at cycle 0, done SHALL be high in cycle 1+16*(SETTLE+1), which is cycle 33 for SETTLE=1 and cycle 17 for SETTLE=0.
REQ-020 DONE SHALL last one cycle with done=1, busy=0 and S3..S0=0, then go to IDLE unless start=1, in which case it goes to SCAN (back-to-back scans, no idle gap).
REQ-021 start SHALL be ignored throughout SCAN, with no restart and no effect on index, counter or DATA.
REQ-022 DATA SHALL change only on the DONE-entry edge and SHALL stay stable during SCAN, so partial scans are never visible.
REQ-023 The index SHALL never wrap from 15 to 0 inside SCAN; 15 is always the terminal channel.
REQ-024 The shadow register SHALL be fully overwritten each scan and SHALL carry no bits from a previous scan.
REQ-025 All outputs SHALL be registered, with no combinational path from start or Y to any output.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, S3..S0=0, DATA=16'h0000, shadow register=0, index=0 and counter=0.
REQ-027 Reset SHALL take priority over start in the same cycle.
REQ-028 Reset asserted mid-scan SHALL abort the scan, produce no done pulse, and leave DATA at 0 rather than a partial word.
REQ-029 After rst is released, start SHALL be required to begin a new scan.

Verification
REQ-030 With SETTLE=1, mux inputs {A..P}=16'b0000000000000001 (P=1), and a start pulse at cycle 0, the bench SHALL see done in cycle 33, DATA=16'h8000, and busy high for cycles 1..32.
REQ-031 With SETTLE=1, the bench SHALL check that select steps 0,0,1,1,2,2,...,15,15 in cycles 1..32, each value held exactly 2 cycles.
REQ-032 With SETTLE=0, A=C=E=...=O=1 (even channels), others 0, and start at cycle 0, the bench SHALL see done at cycle 17 and DATA=16'h5555.
REQ-033 With start held high continuously, the bench SHALL see done pulses at cycles 33, 66 and 99 (SETTLE=1), with busy low only in the done cycles.
REQ-034 With rst pulsed at cycle 10 of a scan, the bench SHALL see busy=0, S=0 and DATA=0 the next cycle, no done pulse, and a subsequent start completing normally.
REQ-035 With start pulsed again at cycle 5 of a scan, the bench SHALL see no effect and done still at cycle 33.
